// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for the parametrised synchronous FIFO:
//   - ptr_width / cnt_width : sizing helpers for read/write pointers and the
//                             occupancy counter
//   - next_ptr              : pointer increment that wraps DEPTH-1 -> 0, so
//                             non-power-of-two depths work
//   - fifo_status_t         : the registered per-edge status pulses
//                             (wr_ack, overflow, underflow)
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

  typedef struct packed {
    logic wr_ack;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Address width needed to index DEPTH entries (at least one bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Counter width must hold every value 0..DEPTH inclusive.
  function automatic int cnt_width(input int depth);
    return (depth > 0) ? $clog2(depth + 1) : 1;
  endfunction

  // Wrapping increment; the wrap is explicit so DEPTH need not be 2**n.
  function automatic int unsigned next_ptr(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// ---------------------------------------------------------------------------
// sync_fifo_mem
// DEPTH x DATA_W simple dual-port storage for the FIFO. One synchronous
// write port and one asynchronous read port, so the FIFO top can either
// register the read word (standard mode) or present it directly (FWFT).
// Contents are intentionally not reset.
// Ports:
//   clk      in  clock
//   wr_en    in  write strobe (already qualified by the FIFO accept logic)
//   wr_addr  in  write address
//   wr_data  in  write data
//   rd_addr  in  read address
//   rd_data  out word currently stored at rd_addr
// ---------------------------------------------------------------------------
module sync_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write: only accepted writes reach this strobe.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, exported occupancy and standard or first-word-fall-through
// read mode.
// Parameters:
//   DATA_W    data width
//   DEPTH     number of entries (any value >= 2)
//   AF_LEVEL  almost_full  when count >= AF_LEVEL
//   AE_LEVEL  almost_empty when count <= AE_LEVEL
//   FWFT      0: data_out registered on an accepted read
//             1: head word shown combinationally, rd_en pops it
// Ports:
//   clk, rst_n (async active-low)
//   wr_en, data_in               write side
//   rd_en, data_out              read side
//   wr_ack, overflow, underflow  registered pulses for the previous edge
//   full, empty, almost_full, almost_empty, count  occupancy status
// Optional build macro:
//   SYNC_FIFO_SVA_EN  compiles in embedded concurrent assertions; the logic
//                     is identical with or without it.
// ---------------------------------------------------------------------------
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int FWFT     = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         rd_en,
  output logic [DATA_W-1:0]            data_out,
  output logic                         wr_ack,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [cnt_width(DEPTH)-1:0]  count
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] head_data;
  logic              wr_accept;
  logic              rd_accept;
  fifo_status_t      status_d;
  fifo_status_t      status_q;

  // Flags come straight from the registered count, so they never depend on
  // the same-cycle request inputs.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;

  // A request is honoured only against the pre-edge state: a write into a
  // full FIFO is refused even if a read drains a slot on the same edge, and
  // a read of an empty FIFO is refused even if a write lands on that edge.
  assign wr_accept = wr_en & ~full;
  assign rd_accept = rd_en & ~empty;

  // Status pulses describing what the coming edge does with the requests.
  always_comb begin
    status_d           = '0;
    status_d.wr_ack    = wr_accept;
    status_d.overflow  = wr_en & full;
    status_d.underflow = rd_en & empty;
  end

  assign wr_ack    = status_q.wr_ack;
  assign overflow  = status_q.overflow;
  assign underflow = status_q.underflow;

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (head_data)
  );

  // Pointer, occupancy and status registers. Reset discards everything
  // stored by returning both pointers and the count to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      status_q <= '0;
    end else begin
      status_q <= status_d;
      if (wr_accept) begin
        wr_ptr <= PTR_W'(next_ptr(32'(wr_ptr), DEPTH));
      end
      if (rd_accept) begin
        rd_ptr <= PTR_W'(next_ptr(32'(rd_ptr), DEPTH));
      end
      unique case ({wr_accept, rd_accept})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // The head word is shown as soon as it exists; forcing zero while
      // empty keeps the output free of stale memory contents.
      assign data_out = empty ? '0 : head_data;
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;

      // Standard mode: the popped word appears one edge after rd_en and is
      // held until the next accepted read.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= '0;
        end else if (rd_accept) begin
          dout_q <= head_data;
        end
      end

      assign data_out = dout_q;
    end
  endgenerate

`ifdef SYNC_FIFO_SVA_EN
  // Refused accesses must leave the corresponding pointer untouched, and
  // the count too when nothing else was accepted on that edge.
  a_wr_reject_ptr : assert property (@(posedge clk) disable iff (!rst_n)
    (wr_en && full) |=> $stable(wr_ptr));
  a_rd_reject_ptr : assert property (@(posedge clk) disable iff (!rst_n)
    (rd_en && empty) |=> $stable(rd_ptr));
  a_wr_reject_cnt : assert property (@(posedge clk) disable iff (!rst_n)
    (wr_en && full && !rd_en) |=> $stable(count_q));
  a_rd_reject_cnt : assert property (@(posedge clk) disable iff (!rst_n)
    (rd_en && empty && !wr_en) |=> $stable(count_q));
  a_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= DEPTH_C);
  a_full_empty : assert property (@(posedge clk) disable iff (!rst_n)
    !(full && empty));
  a_ack_ovf : assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_ack && overflow));
  a_reset_cnt : assert property (@(posedge clk)
    $fell(rst_n) |=> (count_q == '0));
`else
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
// Drives two FIFO instances from one shared input stream:
//   dut_a : DEPTH 16, standard read, default thresholds
//   dut_b : DEPTH 5,  FWFT read, AF_LEVEL 4, AE_LEVEL 2
// A queue-based reference model per instance predicts every output; a
// vector table and a few hand-written sequences add fixed expectations.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_in;

  logic [7:0] a_data_out;
  logic       a_wr_ack, a_overflow, a_underflow;
  logic       a_full, a_empty, a_almost_full, a_almost_empty;
  logic [4:0] a_count;

  logic [7:0] b_data_out;
  logic       b_wr_ack, b_overflow, b_underflow;
  logic       b_full, b_empty, b_almost_full, b_almost_empty;
  logic [2:0] b_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] ma_dout;
  logic       ma_ack, ma_ovf, ma_udf;
  logic       mb_ack, mb_ovf, mb_udf;

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(16), .FWFT(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(a_data_out), .wr_ack(a_wr_ack),
    .overflow(a_overflow), .underflow(a_underflow), .full(a_full),
    .empty(a_empty), .almost_full(a_almost_full),
    .almost_empty(a_almost_empty), .count(a_count)
  );

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(2), .FWFT(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(b_data_out), .wr_ack(b_wr_ack),
    .overflow(b_overflow), .underflow(b_underflow), .full(b_full),
    .empty(b_empty), .almost_full(b_almost_full),
    .almost_empty(b_almost_empty), .count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    int         cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ack;
    logic       ovf;
    logic       udf;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[35];

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Predicts the effect of the coming edge from the occupancy seen before it.
  task automatic modelEdge(input logic w, input logic r, input logic [7:0] d);
    logic wa, ra, wb, rb;
    wa = w && (qa.size() < 16);
    ra = r && (qa.size() > 0);
    ma_ack = wa; ma_ovf = w && !wa; ma_udf = r && !ra;
    if (ra) begin
      ma_dout = qa.pop_front();
    end
    if (wa) qa.push_back(d);
    wb = w && (qb.size() < 5);
    rb = r && (qb.size() > 0);
    mb_ack = wb; mb_ovf = w && !wb; mb_udf = r && !rb;
    if (rb) void'(qb.pop_front());
    if (wb) qb.push_back(d);
  endtask

  task automatic modelReset();
    qa.delete();
    qb.delete();
    ma_dout = 8'h00;
    ma_ack = 0; ma_ovf = 0; ma_udf = 0;
    mb_ack = 0; mb_ovf = 0; mb_udf = 0;
  endtask

  task automatic checkOutput();
    int na, nb;
    na = qa.size();
    nb = qb.size();
    checkVal("a_count", int'(a_count), na);
    checkVal("a_full", int'(a_full), int'(na == 16));
    checkVal("a_empty", int'(a_empty), int'(na == 0));
    checkVal("a_almost_full", int'(a_almost_full), int'(na >= 15));
    checkVal("a_almost_empty", int'(a_almost_empty), int'(na <= 1));
    checkVal("a_wr_ack", int'(a_wr_ack), int'(ma_ack));
    checkVal("a_overflow", int'(a_overflow), int'(ma_ovf));
    checkVal("a_underflow", int'(a_underflow), int'(ma_udf));
    checkVal("a_data_out", int'(a_data_out), int'(ma_dout));
    checkVal("b_count", int'(b_count), nb);
    checkVal("b_full", int'(b_full), int'(nb == 5));
    checkVal("b_empty", int'(b_empty), int'(nb == 0));
    checkVal("b_almost_full", int'(b_almost_full), int'(nb >= 4));
    checkVal("b_almost_empty", int'(b_almost_empty), int'(nb <= 2));
    checkVal("b_wr_ack", int'(b_wr_ack), int'(mb_ack));
    checkVal("b_overflow", int'(b_overflow), int'(mb_ovf));
    checkVal("b_underflow", int'(b_underflow), int'(mb_udf));
    if (nb > 0) checkVal("b_data_out", int'(b_data_out), int'(qb[0]));
  endtask

  // Drives one cycle from a negedge, lets the posedge act, checks at the
  // following negedge.
  task automatic applyStimulus(input logic w, input logic r, input logic [7:0] d);
    wr_en = w; rd_en = r; data_in = d;
    modelEdge(w, r, d);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic checkTable(input int i, input vec_t v);
    checkVal($sformatf("vec%0d_count", i), int'(a_count), v.cnt);
    checkVal($sformatf("vec%0d_full", i), int'(a_full), int'(v.full));
    checkVal($sformatf("vec%0d_empty", i), int'(a_empty), int'(v.empty));
    checkVal($sformatf("vec%0d_af", i), int'(a_almost_full), int'(v.af));
    checkVal($sformatf("vec%0d_ae", i), int'(a_almost_empty), int'(v.ae));
    checkVal($sformatf("vec%0d_ack", i), int'(a_wr_ack), int'(v.ack));
    checkVal($sformatf("vec%0d_ovf", i), int'(a_overflow), int'(v.ovf));
    checkVal($sformatf("vec%0d_udf", i), int'(a_underflow), int'(v.udf));
    checkVal($sformatf("vec%0d_dout", i), int'(a_data_out), int'(v.dout));
  endtask

  // Checks the state both instances must show while reset is held.
  task automatic checkResetState(input string tag);
    checkVal({tag, "_a_count"}, int'(a_count), 0);
    checkVal({tag, "_a_empty"}, int'(a_empty), 1);
    checkVal({tag, "_a_full"}, int'(a_full), 0);
    checkVal({tag, "_a_ae"}, int'(a_almost_empty), 1);
    checkVal({tag, "_a_af"}, int'(a_almost_full), 0);
    checkVal({tag, "_a_pulses"}, int'({a_wr_ack, a_overflow, a_underflow}), 0);
    checkVal({tag, "_a_dout"}, int'(a_data_out), 0);
    checkVal({tag, "_b_count"}, int'(b_count), 0);
    checkVal({tag, "_b_empty"}, int'(b_empty), 1);
    checkVal({tag, "_b_ae"}, int'(b_almost_empty), 1);
    checkVal({tag, "_b_pulses"}, int'({b_wr_ack, b_overflow, b_underflow}), 0);
  endtask

  initial begin
    // Build the vector table: 16 writes, one overflowing write, 16 reads,
    // one underflowing read, one idle cycle (all for the 16-deep instance).
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{wr: 1, rd: 0, din: 8'(i + 1), cnt: i + 1, full: (i == 15),
                  empty: 0, af: (i + 1 >= 15), ae: (i + 1 <= 1), ack: 1,
                  ovf: 0, udf: 0, dout: 8'h00};
    end
    vecs[16] = '{wr: 1, rd: 0, din: 8'h11, cnt: 16, full: 1, empty: 0, af: 1,
                 ae: 0, ack: 0, ovf: 1, udf: 0, dout: 8'h00};
    for (int k = 0; k < 16; k++) begin
      vecs[17 + k] = '{wr: 0, rd: 1, din: 8'h00, cnt: 15 - k, full: 0,
                       empty: (k == 15), af: (15 - k >= 15), ae: (15 - k <= 1),
                       ack: 0, ovf: 0, udf: 0, dout: 8'(k + 1)};
    end
    vecs[33] = '{wr: 0, rd: 1, din: 8'h00, cnt: 0, full: 0, empty: 1, af: 0,
                 ae: 1, ack: 0, ovf: 0, udf: 1, dout: 8'h10};
    vecs[34] = '{wr: 0, rd: 0, din: 8'h00, cnt: 0, full: 0, empty: 1, af: 0,
                 ae: 1, ack: 0, ovf: 0, udf: 0, dout: 8'h10};

    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
    modelReset();
    #1;
    checkResetState("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < 35; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].din);
      checkTable(i, vecs[i]);
    end

    $display("[TB] simultaneous read/write corners");
    applyStimulus(1, 1, 8'h21);
    checkVal("simul0_a_count", int'(a_count), 1);
    checkVal("simul0_a_udf", int'(a_underflow), 1);
    checkVal("simul0_a_ack", int'(a_wr_ack), 1);
    applyStimulus(1, 0, 8'h22);
    applyStimulus(1, 0, 8'h23);
    applyStimulus(1, 1, 8'h24);
    checkVal("simul3_a_count", int'(a_count), 3);
    checkVal("simul3_b_count", int'(b_count), 3);
    checkVal("simul3_a_flags", int'({a_wr_ack, a_overflow, a_underflow}), 3'b100);
    checkVal("simul3_a_dout", int'(a_data_out), 8'h21);
    for (int i = 0; i < 13; i++) applyStimulus(1, 0, 8'(8'h30 + i));
    checkVal("fill_a_full", int'(a_full), 1);
    applyStimulus(1, 1, 8'h40);
    checkVal("simulF_a_count", int'(a_count), 15);
    checkVal("simulF_a_ovf", int'(a_overflow), 1);
    checkVal("simulF_a_ack", int'(a_wr_ack), 0);
    checkVal("simulF_a_dout", int'(a_data_out), 8'h22);
    checkVal("simulF_b_count", int'(b_count), 4);
    checkVal("simulF_b_ovf", int'(b_overflow), 1);
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 8'h00);

    $display("[TB] first-word-fall-through");
    applyStimulus(1, 0, 8'hA5);
    checkVal("fwft_b_dout", int'(b_data_out), 8'hA5);
    checkVal("fwft_b_count", int'(b_count), 1);
    applyStimulus(0, 1, 8'h00);
    checkVal("fwft_b_empty", int'(b_empty), 1);
    checkVal("fwft_a_dout", int'(a_data_out), 8'hA5);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        // Mid-burst async reset, asserted away from any clock edge.
        #2;
        rst_n = 1'b0;
        wr_en = 1'b1;
        #1;
        checkResetState("midreset");
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
      applyStimulus(1'($urandom_range(0, 99) < ((n / 100) % 2 ? 35 : 65)),
                    1'($urandom_range(0, 99) < ((n / 100) % 2 ? 65 : 35)),
                    8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock synchronous FIFO; next generation of the team's 16x8 FIFO.
- Adds: arbitrary depth/width, programmable almost-full/almost-empty levels, exported fill level, selectable standard or first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer blocks in one clock domain; keeps the wr_ack/overflow/underflow status protocol of the existing FIFO.

Parameters:
- DATA_W, 8, data width in bits (>=1)
- DEPTH, 16, number of entries (>=2, not required to be a power of two)
- AF_LEVEL, DEPTH-1, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- data_in  in  DATA_W  write data
- rd_en  in  1  read request (FWFT: pop/acknowledge of data_out)
- data_out  out  DATA_W  read data
- wr_ack  out  1  registered pulse: write accepted on previous edge
- overflow  out  1  registered pulse: write rejected (full) on previous edge
- underflow  out  1  registered pulse: read rejected (empty) on previous edge
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (async assert, sync-released use): wr_ptr=0, rd_ptr=0, count=0, data_out=0, wr_ack/overflow/underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0). Memory contents not reset. Reset mid-operation discards all stored data.
- Accept rules, evaluated on pre-edge state: write accepted iff wr_en && !full; read accepted iff rd_en && !empty.
- Accepted write: mem[wr_ptr]<=data_in; wr_ptr wraps DEPTH-1 -> 0; wr_ack=1 next cycle, else 0.
- Rejected write: overflow=1 next cycle; pointers/count unchanged.
- Accepted read: rd_ptr wraps DEPTH-1 -> 0. Standard mode: data_out<=mem[rd_ptr], visible 1 cycle after rd_en; data_out holds otherwise. FWFT: data_out=mem[rd_ptr] combinationally whenever !empty (head word visible without rd_en); rd_en pops; data_out undefined-but-stable-0 is not required when empty.
- Rejected read: underflow=1 next cycle.
- count: +1 on write only, -1 on read only, unchanged on both or neither accepted.
- Simultaneous wr/rd when empty: write accepted, read rejected (underflow). When full: read accepted, write rejected (overflow). Otherwise both accepted, count unchanged.
- Flags full/empty/almost_* derived combinationally from registered count; no glitch-sensitive paths.

Optional Feature:
- SYNC_FIFO_SVA_EN: when defined, embedded concurrent assertions compiled in: no wr_ptr/rd_ptr/count change on rejected access; count never > DEPTH; full&&empty never both 1; wr_ack and overflow never both 1; count==0 one cycle after rst_n fall. Without it: no assertion code, identical RTL behaviour.

Decomposition:
- Package sync_fifo_pkg: function for pointer width/count width, pointer-increment-with-wrap function, status struct typedef (wr_ack, overflow, underflow).
- One sub-module: sync_fifo_mem (DEPTH x DATA_W simple dual-port array, sync write, async read address path) instanced by sync_fifo_param.

Test Plan:
- Reset then 16 writes (0x01..0x10), DEPTH=16 -> wr_ack each cycle, count 16, full=1, almost_full from count 15.
- 17th write while full -> overflow=1 one cycle later, wr_ack=0, count stays 16.
- 16 reads, standard mode -> data_out 0x01..0x10 each 1 cycle after rd_en, empty=1 at end; extra read -> underflow=1.
- DEPTH=5, 12 interleaved writes/reads -> pointers wrap 4->0, data order preserved, count matches reference model.
- Simultaneous wr/rd at count 0, 3 and DEPTH -> respectively (underflow, count 1), (count 3 unchanged), (overflow, count DEPTH-1).
- FWFT=1: write 0xA5 into empty -> data_out=0xA5 with no rd_en; rd_en pops, empty=1; rst_n low mid-burst -> count 0, flags reset immediately.
